glitch_pulse_gen: RTL and testbench

GLITCH_PULSE_GEN -- requirements
Module: glitch_pulse_gen

---
 rtl/glitch_pulse_gen.sv | 177 +++++++++++++++++
 tb/tb_glitch_pulse_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_pulse_gen.sv
// Purpose : trigger-armed generator of a programmable train of glitch pulses.
// Latency : first pulse goes active cfg_delay+1 cycles after the sampled trigger edge; all outputs registered.
// Backpr. : none; strobes (arm/abort) and trigger are sampled every cycle, arm is ignored outside IDLE.
//
// Ports:
//   clk, rst            - single rising-edge clock, asynchronous active-low reset
//   cfg_delay/width/gap/count - train shape (width/gap/count are "minus one" encoded)
//   arm, abort          - one-cycle strobes; abort wins over everything
//   trigger             - synchronous level, rising edge fires the train while ARMED
//   glitch_out          - pulse output, OUT_POL when active
//   armed, busy, done   - status; done is a one-cycle completion strobe
//   pulse_idx           - 0-based index of the current/last pulse
module glitch_pulse_gen #(
    parameter int unsigned DELAY_W = 32,
    parameter int unsigned WIDTH_W = 8,
    parameter int unsigned GAP_W   = 8,
    parameter int unsigned COUNT_W = 8,
    parameter logic        OUT_POL = 1'b1,
    parameter logic        REARM   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [WIDTH_W-1:0] cfg_width,
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger,
    output logic               glitch_out,
    output logic               armed,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pulse_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_GAP
    } state_t;

    state_t state, state_nxt;

    // Shadow copies of the configuration, captured on arm.
    logic [DELAY_W-1:0] delay_s, delay_s_nxt;
    logic [WIDTH_W-1:0] width_s, width_s_nxt;
    logic [GAP_W-1:0]   gap_s,   gap_s_nxt;
    logic [COUNT_W-1:0] count_s, count_s_nxt;

    // Per-phase down counters, each as wide as the field it times.
    logic [DELAY_W-1:0] dcnt, dcnt_nxt;
    logic [WIDTH_W-1:0] wcnt, wcnt_nxt;
    logic [GAP_W-1:0]   gcnt, gcnt_nxt;

    logic [COUNT_W-1:0] idx_nxt;
    logic               active_nxt;
    logic               done_nxt;

    logic               trig_prev;
    logic               trig_rise;

    assign trig_rise = trigger & ~trig_prev;

    always_comb begin
        state_nxt   = state;
        delay_s_nxt = delay_s;
        width_s_nxt = width_s;
        gap_s_nxt   = gap_s;
        count_s_nxt = count_s;
        dcnt_nxt    = dcnt;
        wcnt_nxt    = wcnt;
        gcnt_nxt    = gcnt;
        idx_nxt     = pulse_idx;
        active_nxt  = 1'b0;
        done_nxt    = 1'b0;

        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        delay_s_nxt = cfg_delay;
                        width_s_nxt = cfg_width;
                        gap_s_nxt   = cfg_gap;
                        count_s_nxt = cfg_count;
                        idx_nxt     = '0;
                        state_nxt   = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig_rise) begin
                        dcnt_nxt  = delay_s;
                        idx_nxt   = '0;
                        state_nxt = S_DELAY;
                    end
                end
                S_DELAY: begin
                    // Counter reaching zero means this edge is edge E+delay+1.
                    if (dcnt == '0) begin
                        wcnt_nxt   = width_s;
                        active_nxt = 1'b1;
                        state_nxt  = S_PULSE;
                    end else begin
                        dcnt_nxt = dcnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (wcnt == '0) begin
                        // Comparing the index (instead of counting up to count+1)
                        // keeps an all-ones count from overflowing the counter.
                        if (pulse_idx == count_s) begin
                            done_nxt  = 1'b1;
                            state_nxt = REARM ? S_ARMED : S_IDLE;
                        end else begin
                            gcnt_nxt  = gap_s;
                            state_nxt = S_GAP;
                        end
                    end else begin
                        wcnt_nxt   = wcnt - 1'b1;
                        active_nxt = 1'b1;
                    end
                end
                S_GAP: begin
                    if (gcnt == '0) begin
                        wcnt_nxt   = width_s;
                        idx_nxt    = pulse_idx + 1'b1;
                        active_nxt = 1'b1;
                        state_nxt  = S_PULSE;
                    end else begin
                        gcnt_nxt = gcnt - 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            delay_s    <= '0;
            width_s    <= '0;
            gap_s      <= '0;
            count_s    <= '0;
            dcnt       <= '0;
            wcnt       <= '0;
            gcnt       <= '0;
            trig_prev  <= 1'b0;
            glitch_out <= ~OUT_POL;
            armed      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pulse_idx  <= '0;
        end else begin
            state      <= state_nxt;
            delay_s    <= delay_s_nxt;
            width_s    <= width_s_nxt;
            gap_s      <= gap_s_nxt;
            count_s    <= count_s_nxt;
            dcnt       <= dcnt_nxt;
            wcnt       <= wcnt_nxt;
            gcnt       <= gcnt_nxt;
            trig_prev  <= trigger;
            glitch_out <= active_nxt ? OUT_POL : ~OUT_POL;
            armed      <= (state_nxt == S_ARMED);
            busy       <= (state_nxt == S_DELAY) || (state_nxt == S_PULSE) ||
                          (state_nxt == S_GAP);
            done       <= done_nxt;
            pulse_idx  <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Purpose : self-checking bench for glitch_pulse_gen with two instances
//           (A: OUT_POL=1 REARM=0, B: OUT_POL=0 REARM=1) sharing cfg and reset.
// Checks  : observed {glitch_out, done, busy, armed, pulse_idx} vs. a train model.
module tb_glitch_pulse_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cfg_delay = '0;
    logic [7:0]  cfg_width = '0;
    logic [7:0]  cfg_gap   = '0;
    logic [7:0]  cfg_count = '0;
    logic        arm_a = 1'b0, abort_a = 1'b0, trig_a = 1'b0;
    logic        arm_b = 1'b0, abort_b = 1'b0, trig_b = 1'b0;
    logic        glitch_a, armed_a, busy_a, done_a;
    logic        glitch_b, armed_b, busy_b, done_b;
    logic [7:0]  idx_a, idx_b;
    logic [11:0] obs_a, obs_b, exp_v;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign obs_a = {glitch_a, done_a, busy_a, armed_a, idx_a};
    assign obs_b = {glitch_b, done_b, busy_b, armed_b, idx_b};

    glitch_pulse_gen #(.OUT_POL(1'b1), .REARM(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
        .arm(arm_a), .abort(abort_a), .trigger(trig_a),
        .glitch_out(glitch_a), .armed(armed_a), .busy(busy_a), .done(done_a), .pulse_idx(idx_a)
    );

    glitch_pulse_gen #(.OUT_POL(1'b0), .REARM(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
        .arm(arm_b), .abort(abort_b), .trigger(trig_b),
        .glitch_out(glitch_b), .armed(armed_b), .busy(busy_b), .done(done_b), .pulse_idx(idx_b)
    );

    // Offset (in cycles after the trigger-sampling edge) of the done strobe.
    function automatic int train_len(int d, int w, int g, int c);
        return d + 1 + (c + 1) * (w + 1) + c * (g + 1);
    endfunction

    // Expected {glitch, done, busy, armed, idx} k cycles after the trigger edge.
    // Pulse i starts at d+1 + i*(w+1+g+1) and lasts w+1 cycles.
    function automatic logic [11:0] model(int d, int w, int g, int c,
                                          logic rearm, logic pol, int k);
        int   first, period, fin, idx;
        logic act;
        first  = d + 1;
        period = w + g + 2;
        fin    = train_len(d, w, g, c);
        act    = (k >= first) && (k < fin) && (((k - first) % period) <= w);
        if (k < first) idx = 0;
        else begin
            idx = (k - first) / period;
            if (idx > c) idx = c;
        end
        return {(act ? pol : ~pol), (k == fin), (k < fin), ((k >= fin) ? rearm : 1'b0), idx[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_cfg(input logic sel_b, input int d, input int w, input int g, input int c);
        cfg_delay = 32'(d);
        cfg_width = 8'(w);
        cfg_gap   = 8'(g);
        cfg_count = 8'(c);
        if (sel_b) arm_b = 1'b1; else arm_a = 1'b1;
        tick();
        arm_a = 1'b0;
        arm_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (obs_a !== 12'h000) begin n_err++; $display("FAIL reset_a got %h want %h", obs_a, 12'h000); end
        n_vec++;
        if (obs_b !== 12'h800) begin n_err++; $display("FAIL reset_b got %h want %h", obs_b, 12'h800); end
        #3 rst = 1'b1;
        repeat (2) tick();
        n_vec++;
        if (obs_a !== 12'h000) begin n_err++; $display("FAIL post_reset_a got %h want %h", obs_a, 12'h000); end
    endtask

    task automatic test_single_pulse();
        arm_cfg(1'b0, 50, 34, 0, 0);
        trig_a = 1'b1;
        tick();
        for (int k = 0; k <= train_len(50, 34, 0, 0) + 2; k++) begin
            exp_v = model(50, 34, 0, 0, 1'b0, 1'b1, k);
            n_vec++;
            if (obs_a !== exp_v) begin n_err++; $display("FAIL single k=%0d got %h want %h", k, obs_a, exp_v); end
            tick();
        end
        trig_a = 1'b0;
        tick();
    endtask

    task automatic test_multi_pulse();
        arm_cfg(1'b0, 0, 0, 1, 2);
        trig_a = 1'b1;
        tick();
        for (int k = 0; k <= train_len(0, 0, 1, 2) + 2; k++) begin
            exp_v = model(0, 0, 1, 2, 1'b0, 1'b1, k);
            n_vec++;
            if (obs_a !== exp_v) begin n_err++; $display("FAIL multi k=%0d got %h want %h", k, obs_a, exp_v); end
            tick();
        end
        trig_a = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        arm_cfg(1'b0, 2, 9, 0, 1);
        trig_a = 1'b1;
        tick();
        // Pulse occupies offsets 3..12; offset 5 is its third cycle.
        for (int k = 0; k <= 5; k++) begin
            exp_v = model(2, 9, 0, 1, 1'b0, 1'b1, k);
            n_vec++;
            if (obs_a !== exp_v) begin n_err++; $display("FAIL abort_pre k=%0d got %h want %h", k, obs_a, exp_v); end
            if (k < 5) tick();
        end
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        for (int k = 0; k < 15; k++) begin
            n_vec++;
            if (obs_a[11:8] !== 4'b0000) begin
                n_err++; $display("FAIL abort_post k=%0d got %b want 0000", k, obs_a[11:8]);
            end
            tick();
        end
        trig_a = 1'b0;
        tick();
    endtask

    task automatic test_abort_priority();
        arm_a   = 1'b1;
        abort_a = 1'b1;
        tick();
        arm_a   = 1'b0;
        abort_a = 1'b0;
        n_vec++;
        if (obs_a[11:8] !== 4'b0000) begin n_err++; $display("FAIL abort_over_arm got %b want 0000", obs_a[11:8]); end
        arm_cfg(1'b0, 0, 0, 0, 0);
        n_vec++;
        if (obs_a[11:8] !== 4'b0001) begin n_err++; $display("FAIL armed_flag got %b want 0001", obs_a[11:8]); end
        trig_a  = 1'b1;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (obs_a[11:8] !== 4'b0000) begin
                n_err++; $display("FAIL abort_over_trig k=%0d got %b want 0000", k, obs_a[11:8]);
            end
            tick();
        end
        trig_a = 1'b0;
        tick();
    endtask

    task automatic test_cfg_change();
        arm_cfg(1'b0, 3, 34, 2, 1);
        trig_a = 1'b1;
        tick();
        for (int k = 0; k <= train_len(3, 34, 2, 1) + 2; k++) begin
            exp_v = model(3, 34, 2, 1, 1'b0, 1'b1, k);
            n_vec++;
            if (obs_a !== exp_v) begin n_err++; $display("FAIL cfg_change k=%0d got %h want %h", k, obs_a, exp_v); end
            if (k == 10) begin
                cfg_width = 8'h05;
                cfg_delay = 32'd0;
                arm_a     = 1'b1;
            end else begin
                arm_a = 1'b0;
            end
            tick();
        end
        trig_a = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int d, w, g, c;
        for (int t = 0; t < 8; t++) begin
            d = int'($urandom_range(0, 7));
            w = int'($urandom_range(0, 5));
            g = int'($urandom_range(0, 4));
            c = int'($urandom_range(0, 3));
            arm_cfg(1'b0, d, w, g, c);
            repeat (int'($urandom_range(0, 3))) tick();
            trig_a = 1'b1;
            tick();
            for (int k = 0; k <= train_len(d, w, g, c) + 2; k++) begin
                exp_v = model(d, w, g, c, 1'b0, 1'b1, k);
                n_vec++;
                if (obs_a !== exp_v) begin
                    n_err++; $display("FAIL random t=%0d k=%0d got %h want %h", t, k, obs_a, exp_v);
                end
                tick();
            end
            trig_a = 1'b0;
            tick();
        end
    endtask

    task automatic test_count_wrap();
        arm_cfg(1'b0, 0, 0, 0, 255);
        trig_a = 1'b1;
        tick();
        for (int k = 0; k <= train_len(0, 0, 0, 255) + 2; k++) begin
            exp_v = model(0, 0, 0, 255, 1'b0, 1'b1, k);
            n_vec++;
            if (obs_a !== exp_v) begin n_err++; $display("FAIL count_wrap k=%0d got %h want %h", k, obs_a, exp_v); end
            tick();
        end
        trig_a = 1'b0;
        tick();
    endtask

    task automatic test_rearm();
        trig_b = 1'b1;
        repeat (2) tick();
        arm_cfg(1'b1, 2, 3, 1, 1);
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (obs_b !== 12'h900) begin n_err++; $display("FAIL held_trig k=%0d got %h want %h", k, obs_b, 12'h900); end
            tick();
        end
        for (int r = 0; r < 2; r++) begin
            trig_b = 1'b0;
            tick();
            trig_b = 1'b1;
            tick();
            for (int k = 0; k <= train_len(2, 3, 1, 1) + 2; k++) begin
                exp_v = model(2, 3, 1, 1, 1'b1, 1'b0, k);
                n_vec++;
                if (obs_b !== exp_v) begin
                    n_err++; $display("FAIL rearm r=%0d k=%0d got %h want %h", r, k, obs_b, exp_v);
                end
                tick();
            end
        end
    endtask

    task automatic test_async_reset();
        abort_b = 1'b1;
        trig_b  = 1'b0;
        tick();
        abort_b = 1'b0;
        arm_cfg(1'b1, 1, 9, 0, 0);
        trig_b = 1'b1;
        tick();
        repeat (4) tick();
        exp_v = model(1, 9, 0, 0, 1'b1, 1'b0, 4);
        n_vec++;
        if (obs_b !== exp_v) begin n_err++; $display("FAIL pre_reset_pulse got %h want %h", obs_b, exp_v); end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (obs_b !== 12'h800) begin n_err++; $display("FAIL async_reset_b got %h want %h", obs_b, 12'h800); end
        n_vec++;
        if (obs_a !== 12'h000) begin n_err++; $display("FAIL async_reset_a got %h want %h", obs_a, 12'h000); end
        #1 rst = 1'b1;
        tick();
        trig_b = 1'b0;
        tick();
        trig_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if (obs_b !== 12'h800) begin n_err++; $display("FAIL no_arm_after_reset k=%0d got %h want %h", k, obs_b, 12'h800); end
        end
        trig_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_multi_pulse();
        test_abort();
        test_abort_priority();
        test_cfg_change();
        test_random();
        test_count_wrap();
        test_rearm();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
